// File: rtl/cpu_bus_sync_pkg.sv
// Shared types and helpers for the HuCard CPU bus front-end.
package cpu_bus_pkg;

  typedef enum logic [1:0] {IDLE, QUAL, ACTIVE, RELEASE} bus_state_t;

  typedef enum logic {RD, WR} acc_kind_t;

  // TurboGrafx carts see the data bus mirrored; swap bit i with bit 7-i.
  function automatic logic [7:0] bitrev8(input logic [7:0] d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

endpackage

// File: rtl/cpu_bus_sync_sync_ff.sv
// Multi-stage pin synchroniser with a configurable reset level.
module sync_ff #(
  parameter int             W       = 1,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= RST_VAL;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/cpu_bus_sync.sv
// Synchronises and glitch-filters the asynchronous HuCard CPU bus, emitting
// one rd_stb per qualified read start and one wr_stb per completed write.
module cpu_bus_sync
  import cpu_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 3,
  parameter int ADDR_W      = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_data,
  input  logic              cpu_oe,
  input  logic              cpu_we,
  input  logic              region,
  output logic              rd_stb,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdat,
  output logic              bus_act,
  output logic [7:0]        glitch_cnt
);

  localparam logic [3:0] FILT_N  = 4'(FILT_CYC);
  localparam int         FW      = $clog2(SYNC_STAGES + 1);
  localparam logic [FW-1:0] FLUSH_N = FW'(SYNC_STAGES);

  logic              oe_s, we_s, region_s;
  logic [ADDR_W-1:0] addr_s;
  logic [7:0]        data_s;

  sync_ff #(.W(2), .STAGES(SYNC_STAGES), .RST_VAL(2'b11)) u_sync_strb (
    .clk (clk),
    .rst (rst),
    .d   ({cpu_oe, cpu_we}),
    .q   ({oe_s, we_s})
  );

  sync_ff #(.W(ADDR_W + 9), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_sync_bus (
    .clk (clk),
    .rst (rst),
    .d   ({cpu_addr, cpu_data, region}),
    .q   ({addr_s, data_s, region_s})
  );

  bus_state_t    state;
  acc_kind_t     kind;
  logic [3:0]    fcnt;
  logic          armed;
  logic [FW-1:0] flush_cnt;

  logic own_low, other_high, flushed, glitch_evt, cap_en;

  always_comb begin
    own_low    = (kind == RD) ? !oe_s : !we_s;
    other_high = (kind == RD) ?  we_s :  oe_s;
    flushed    = (flush_cnt == FLUSH_N);
    glitch_evt = ((state == IDLE) && armed && !oe_s && !we_s) ||
                 ((state == QUAL) && !(own_low && other_high));
    // Write data follows the pins whenever the write strobe is seen low.
    cap_en     = (kind == WR) && own_low &&
                 ((state == ACTIVE) || (state == RELEASE) ||
                  ((state == QUAL) && other_high && (fcnt == FILT_N)));
  end

  // rd_stb/wr_stb are single-cycle pulses with no back-pressure; bus_addr and
  // bus_wdat are stable while the matching pulse is high and hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      kind       <= RD;
      fcnt       <= '0;
      armed      <= 1'b0;
      flush_cnt  <= '0;
      rd_stb     <= 1'b0;
      wr_stb     <= 1'b0;
      bus_act    <= 1'b0;
      bus_addr   <= '0;
      bus_wdat   <= '0;
      glitch_cnt <= '0;
    end else begin
      rd_stb <= 1'b0;
      wr_stb <= 1'b0;
      if (!flushed) flush_cnt <= flush_cnt + FW'(1);
      if (glitch_evt && (glitch_cnt != 8'hFF)) glitch_cnt <= glitch_cnt + 8'd1;
      if (cap_en) bus_wdat <= region_s ? bitrev8(data_s) : data_s;

      case (state)
        IDLE: begin
          // Re-arm only once reset-time synchroniser contents have flushed out.
          if (!armed) begin
            if (flushed && oe_s && we_s) armed <= 1'b1;
          end else if (!oe_s && !we_s) begin
            armed <= 1'b0;
          end else if (oe_s != we_s) begin
            state <= QUAL;
            fcnt  <= 4'd1;
            kind  <= oe_s ? WR : RD;
          end
        end
        QUAL: begin
          if (own_low && other_high) begin
            if (fcnt == FILT_N) begin
              state    <= ACTIVE;
              bus_addr <= addr_s;
              bus_act  <= 1'b1;
              rd_stb   <= (kind == RD);
            end else begin
              fcnt <= fcnt + 4'd1;
            end
          end else begin
            state <= IDLE;
            armed <= 1'b0;
          end
        end
        ACTIVE: begin
          if (!own_low) begin
            state <= RELEASE;
            fcnt  <= 4'd1;
          end
        end
        RELEASE: begin
          if (own_low) begin
            state <= ACTIVE;
          end else if (fcnt == FILT_N) begin
            state   <= IDLE;
            bus_act <= 1'b0;
            wr_stb  <= (kind == WR);
          end else begin
            fcnt <= fcnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_sync.sv
// Self-checking bench for cpu_bus_sync: directed scenarios plus randomized
// accesses checked against a pin-level timing model.
module tb_cpu_bus_sync;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_CYC    = 3;
  localparam int ADDR_W      = 21;
  localparam int LAT         = SYNC_STAGES + FILT_CYC + 1;
  localparam int GAP         = LAT + 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_data;
  logic              cpu_oe, cpu_we, region;
  logic              rd_stb, wr_stb, bus_act;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdat, glitch_cnt;

  int n_check = 0;
  int n_pass  = 0;
  int exp_glitch = 0;
  int cyc = 0;

  int                rd_cyc_q[$];
  logic [ADDR_W-1:0] rd_addr_q[$];
  int                wr_cyc_q[$];
  logic [7:0]        wr_dat_q[$];
  logic [7:0]        exp_q[$];
  int                act_n = 0;
  int                overlap_n = 0;

  cpu_bus_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_oe     (cpu_oe),
    .cpu_we     (cpu_we),
    .region     (region),
    .rd_stb     (rd_stb),
    .wr_stb     (wr_stb),
    .bus_addr   (bus_addr),
    .bus_wdat   (bus_wdat),
    .bus_act    (bus_act),
    .glitch_cnt (glitch_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rd_stb === 1'b1) begin
      rd_cyc_q.push_back(cyc);
      rd_addr_q.push_back(bus_addr);
    end
    if (wr_stb === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      wr_dat_q.push_back(bus_wdat);
    end
    if (bus_act === 1'b1) act_n++;
    if (rd_stb === 1'b1 && wr_stb === 1'b1) overlap_n++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit do_rd, input bit do_wr, input int len,
                        output int t_fall, output int t_rise);
    step();
    if (do_rd) cpu_oe = 1'b0;
    if (do_wr) cpu_we = 1'b0;
    t_fall = cyc;
    repeat (len) step();
    cpu_oe = 1'b1;
    cpu_we = 1'b1;
    t_rise = cyc;
    repeat (GAP) step();
  endtask

  // ---------------- reference model helpers ----------------
  function automatic logic [7:0] mirror(input logic [7:0] d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = (r << 1) | 8'(d[i]);
    return r;
  endfunction

  function automatic int sat255(input int g);
    return (g > 255) ? 255 : g;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_check++;
    if ({rd_stb, wr_stb, bus_act} !== 3'b000)
      $display("FAIL reset_strobes: got %b want 000", {rd_stb, wr_stb, bus_act});
    else n_pass++;
    n_check++;
    if (bus_addr !== '0 || bus_wdat !== 8'h00)
      $display("FAIL reset_bus: got addr=%0h wdat=%0h want 0/0", bus_addr, bus_wdat);
    else n_pass++;
    n_check++;
    if (glitch_cnt !== 8'd0)
      $display("FAIL reset_glitch: got %0d want 0", glitch_cnt);
    else n_pass++;
    rst = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_clean_read();
    int rb, wb, ab, tf, tr, got;
    cpu_addr = 21'h01234;
    rb = rd_cyc_q.size(); wb = wr_cyc_q.size(); ab = act_n;
    strobe(1'b1, 1'b0, 20, tf, tr);
    n_check++;
    if (rd_cyc_q.size() - rb != 1)
      $display("FAIL read_count: got %0d want 1", rd_cyc_q.size() - rb);
    else n_pass++;
    got = (rd_cyc_q.size() > rb) ? rd_cyc_q[rb] - tf : -1;
    n_check++;
    if (got != LAT) $display("FAIL read_latency: got %0d want %0d", got, LAT);
    else n_pass++;
    n_check++;
    if (bus_addr !== 21'h01234) $display("FAIL read_addr: got %0h want 1234", bus_addr);
    else n_pass++;
    n_check++;
    if (act_n - ab != 20) $display("FAIL read_act_len: got %0d want 20", act_n - ab);
    else n_pass++;
    n_check++;
    if (wr_cyc_q.size() != wb || bus_act !== 1'b0)
      $display("FAIL read_no_wr: got wr=%0d act=%b want 0/0", wr_cyc_q.size() - wb, bus_act);
    else n_pass++;
  endtask

  task automatic test_write_pce();
    int rb, wb, tf, tr, got;
    region = 1'b0; cpu_addr = 21'h1F00F; cpu_data = 8'h5A;
    repeat (3) step();
    rb = rd_cyc_q.size(); wb = wr_cyc_q.size();
    strobe(1'b0, 1'b1, 15, tf, tr);
    n_check++;
    if (wr_cyc_q.size() - wb != 1 || rd_cyc_q.size() != rb)
      $display("FAIL wr_pce_count: got wr=%0d rd=%0d want 1/0",
               wr_cyc_q.size() - wb, rd_cyc_q.size() - rb);
    else n_pass++;
    got = (wr_cyc_q.size() > wb) ? wr_cyc_q[wb] - tr : -1;
    n_check++;
    if (got != LAT) $display("FAIL wr_pce_latency: got %0d want %0d", got, LAT);
    else n_pass++;
    n_check++;
    if (bus_wdat !== 8'h5A) $display("FAIL wr_pce_data: got %0h want 5a", bus_wdat);
    else n_pass++;
  endtask

  task automatic test_write_tg();
    logic [7:0] din [2];
    logic [7:0] dexp [2];
    int wb, tf, tr;
    din[0] = 8'h01; dexp[0] = 8'h80;
    din[1] = 8'hC3; dexp[1] = 8'hC3;
    region = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cpu_data = din[i];
      repeat (3) step();
      wb = wr_cyc_q.size();
      strobe(1'b0, 1'b1, 10, tf, tr);
      n_check++;
      if (wr_cyc_q.size() - wb != 1 || (wr_cyc_q.size() > wb && wr_dat_q[wb] !== dexp[i]))
        $display("FAIL wr_tg_data%0d: got %0h (n=%0d) want %0h", i, bus_wdat,
                 wr_cyc_q.size() - wb, dexp[i]);
      else n_pass++;
    end
    region = 1'b0;
  endtask

  task automatic test_glitches();
    int rb, wb, tf, tr;
    rb = rd_cyc_q.size(); wb = wr_cyc_q.size();
    strobe(1'b1, 1'b0, 2, tf, tr);
    exp_glitch = sat255(exp_glitch + 1);
    n_check++;
    if (rd_cyc_q.size() != rb || glitch_cnt !== 8'(exp_glitch))
      $display("FAIL glitch_short: got rd=%0d cnt=%0d want 0/%0d",
               rd_cyc_q.size() - rb, glitch_cnt, exp_glitch);
    else n_pass++;
    strobe(1'b1, 1'b1, 5, tf, tr);
    exp_glitch = sat255(exp_glitch + 1);
    n_check++;
    if (rd_cyc_q.size() != rb || wr_cyc_q.size() != wb || glitch_cnt !== 8'(exp_glitch))
      $display("FAIL glitch_both: got rd=%0d wr=%0d cnt=%0d want 0/0/%0d",
               rd_cyc_q.size() - rb, wr_cyc_q.size() - wb, glitch_cnt, exp_glitch);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int wb, ab, tf, tr, got;
    region = 1'b0; cpu_addr = 21'h00777; cpu_data = 8'h11;
    repeat (3) step();
    wb = wr_cyc_q.size(); ab = act_n;
    step();
    cpu_we = 1'b0; tf = cyc;
    repeat (6) step();
    cpu_we = 1'b1; cpu_data = 8'h3C;
    step();
    cpu_we = 1'b0;
    repeat (4) step();
    cpu_we = 1'b1; tr = cyc;
    repeat (GAP) step();
    n_check++;
    if (wr_cyc_q.size() - wb != 1)
      $display("FAIL bounce_count: got %0d want 1", wr_cyc_q.size() - wb);
    else n_pass++;
    got = (wr_cyc_q.size() > wb) ? wr_cyc_q[wb] - tr : -1;
    n_check++;
    if (got != LAT) $display("FAIL bounce_latency: got %0d want %0d", got, LAT);
    else n_pass++;
    n_check++;
    if (bus_wdat !== 8'h3C) $display("FAIL bounce_data: got %0h want 3c", bus_wdat);
    else n_pass++;
    n_check++;
    if (glitch_cnt !== 8'(exp_glitch) || act_n - ab != tr - tf)
      $display("FAIL bounce_glitch_act: got cnt=%0d act=%0d want %0d/%0d",
               glitch_cnt, act_n - ab, exp_glitch, tr - tf);
    else n_pass++;
  endtask

  task automatic test_random();
    int rb, wb, ab, tf, tr, len, got, exp_rd, exp_wr, exp_act;
    bit is_wr, glitchy;
    logic [ADDR_W-1:0] a;
    logic [7:0] d, e;
    logic rg;
    for (int n = 0; n < 40; n++) begin
      is_wr   = 1'($urandom_range(0, 1));
      glitchy = ($urandom_range(0, 3) == 0);
      len     = glitchy ? $urandom_range(1, 2) : $urandom_range(FILT_CYC + 2, 20);
      a       = ADDR_W'($urandom());
      d       = 8'($urandom_range(0, 255));
      rg      = 1'($urandom_range(0, 1));
      cpu_addr = a; cpu_data = d; region = rg;
      repeat (3) step();
      rb = rd_cyc_q.size(); wb = wr_cyc_q.size(); ab = act_n;
      strobe(!is_wr, is_wr, len, tf, tr);
      exp_rd  = (!glitchy && !is_wr) ? 1 : 0;
      exp_wr  = (!glitchy &&  is_wr) ? 1 : 0;
      exp_act = glitchy ? 0 : len;
      if (glitchy) exp_glitch = sat255(exp_glitch + 1);
      if (exp_wr == 1) exp_q.push_back(rg ? mirror(d) : d);
      n_check++;
      if (rd_cyc_q.size() - rb != exp_rd || wr_cyc_q.size() - wb != exp_wr)
        $display("FAIL rand%0d_count: got rd=%0d wr=%0d want %0d/%0d", n,
                 rd_cyc_q.size() - rb, wr_cyc_q.size() - wb, exp_rd, exp_wr);
      else n_pass++;
      n_check++;
      if (glitch_cnt !== 8'(exp_glitch) || act_n - ab != exp_act)
        $display("FAIL rand%0d_glitch_act: got cnt=%0d act=%0d want %0d/%0d", n,
                 glitch_cnt, act_n - ab, exp_glitch, exp_act);
      else n_pass++;
      if (exp_rd == 1) begin
        got = (rd_cyc_q.size() > rb) ? rd_cyc_q[rb] - tf : -1;
        n_check++;
        if (got != LAT || (rd_cyc_q.size() > rb && rd_addr_q[rb] !== a))
          $display("FAIL rand%0d_read: got lat=%0d addr=%0h want %0d/%0h", n,
                   got, bus_addr, LAT, a);
        else n_pass++;
      end
      if (exp_wr == 1) begin
        e = exp_q.pop_front();
        got = (wr_cyc_q.size() > wb) ? wr_cyc_q[wb] - tr : -1;
        n_check++;
        if (got != LAT || (wr_cyc_q.size() > wb && wr_dat_q[wb] !== e) || bus_addr !== a)
          $display("FAIL rand%0d_write: got lat=%0d data=%0h addr=%0h want %0d/%0h/%0h", n,
                   got, bus_wdat, bus_addr, LAT, e, a);
        else n_pass++;
      end
    end
    region = 1'b0;
  endtask

  task automatic test_reset_mid();
    int rb, tf, tr, got;
    cpu_addr = 21'h0ABCD;
    step();
    cpu_oe = 1'b0;
    repeat (LAT + 2) step();
    n_check++;
    if (bus_act !== 1'b1) $display("FAIL midrst_active: got %b want 1", bus_act);
    else n_pass++;
    rst = 1'b1;
    step();
    n_check++;
    if ({rd_stb, wr_stb, bus_act} !== 3'b000 || bus_addr !== '0 || bus_wdat !== 8'h00 ||
        glitch_cnt !== 8'd0)
      $display("FAIL midrst_zero: got act=%b addr=%0h wdat=%0h cnt=%0d want all 0",
               bus_act, bus_addr, bus_wdat, glitch_cnt);
    else n_pass++;
    rst = 1'b0;
    exp_glitch = 0;
    rb = rd_cyc_q.size();
    repeat (20) step();
    cpu_oe = 1'b1;
    repeat (GAP) step();
    n_check++;
    if (rd_cyc_q.size() != rb || glitch_cnt !== 8'd0)
      $display("FAIL midrst_no_pulse: got rd=%0d cnt=%0d want 0/0",
               rd_cyc_q.size() - rb, glitch_cnt);
    else n_pass++;
    strobe(1'b1, 1'b0, 8, tf, tr);
    got = (rd_cyc_q.size() == rb + 1) ? rd_cyc_q[rb] - tf : -1;
    n_check++;
    if (got != LAT) $display("FAIL midrst_rearm: got lat=%0d want %0d", got, LAT);
    else n_pass++;
    rb = rd_cyc_q.size();
    for (int g = 0; g < 300; g++) begin
      step();
      cpu_oe = 1'b0;
      step();
      cpu_oe = 1'b1;
      repeat (5) step();
      exp_glitch = sat255(exp_glitch + 1);
    end
    n_check++;
    if (glitch_cnt !== 8'(exp_glitch) || rd_cyc_q.size() != rb)
      $display("FAIL glitch_saturate: got cnt=%0d rd=%0d want %0d/0",
               glitch_cnt, rd_cyc_q.size() - rb, exp_glitch);
    else n_pass++;
  endtask

  task automatic test_exclusive();
    n_check++;
    if (overlap_n != 0) $display("FAIL rd_wr_overlap: got %0d want 0", overlap_n);
    else n_pass++;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst = 1'b1; cpu_oe = 1'b1; cpu_we = 1'b1;
    cpu_addr = '0; cpu_data = 8'h00; region = 1'b0;
    test_reset();
    test_clean_read();
    test_write_pce();
    test_write_tg();
    test_glitches();
    test_bounce();
    test_random();
    test_reset_mid();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule

// File: doc/cpu_bus_sync.md
Name: cpu_bus_sync

Overview:
- Front-end stage between the asynchronous HuCard CPU bus pins and all clocked cartridge logic: mapper registers, the DAC feeder, and the MCU mailbox.
- Synchronises cpu_oe, cpu_we, cpu_addr, cpu_data and region into the 50 MHz clk domain, and glitch-filters the strobes.
- Emits one single-cycle read pulse per CPU read and one single-cycle write pulse per CPU write.
- Write data is converted to PC Engine bit order (bit-reversed when region=1) before it is presented downstream.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of every pin synchroniser (min 2).
- FILT_CYC, 3, consecutive synchronised cycles a strobe level must hold before it is accepted (1..15).
- ADDR_W, 21, CPU address width.

Ports:
- clk  in  1  master clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  ADDR_W  raw CPU address pins.
- cpu_data  in  8  raw CPU data pins (input view only).
- cpu_oe  in  1  raw CPU read strobe, active low.
- cpu_we  in  1  raw CPU write strobe, active low.
- region  in  1  raw region pin: 1 = TurboGrafx (bit-reversed data bus), 0 = PC Engine.
- rd_stb  out  1  one-cycle pulse: qualified read started.
- wr_stb  out  1  one-cycle pulse: qualified write completed.
- bus_addr  out  ADDR_W  address latched for the current or last access.
- bus_wdat  out  8  write data, PC Engine bit order, valid with wr_stb.
- bus_act  out  1  high from read/write qualification until release qualification.
- glitch_cnt  out  8  saturating count of rejected strobe events.

Behaviour:
- Synchronisation:
  - All inputs pass through SYNC_STAGES flops; the last stage is denoted _s.
  - Synchronisers reset to inactive levels: oe/we = 1, others = 0.
- FSM states: IDLE, QUAL, ACTIVE, RELEASE. A filter counter fcnt is 4 bits wide.
- IDLE:
  - Exactly one of oe_s / we_s low → QUAL, fcnt = 1, record kind (RD/WR).
  - Both low → glitch_cnt++ and stay in IDLE.
- QUAL:
  - Same strobe still low and the other still high → fcnt++.
  - When fcnt reaches FILT_CYC → ACTIVE.
  - Strobe returns high, or the other strobe drops, before that → glitch_cnt++ and go to IDLE.
  - FILT_CYC=1 → ACTIVE on the cycle after entering QUAL.
- Entering ACTIVE:
  - bus_addr <= addr_s and bus_act <= 1.
  - If kind=RD, rd_stb = 1 for exactly that one cycle.
  - Net read latency: falling cpu_oe to rd_stb = SYNC_STAGES + FILT_CYC + 1 clocks (6 at defaults).
- ACTIVE:
  - While the strobe is low, the write data register captures data_s every cycle.
  - Bit order: region_s=1 → bit-reversed (bit0↔bit7, bit1↔bit6, …); region_s=0 → straight.
  - Strobe high → RELEASE, fcnt = 1.
- RELEASE:
  - Strobe high for FILT_CYC consecutive cycles → IDLE, bus_act <= 0.
  - If kind=WR, wr_stb = 1 on that transition cycle, with bus_wdat = the last data captured while the strobe was low.
  - Strobe low again before qualification → ACTIVE; the bounce is absorbed and no glitch is counted.
- Outputs and counters:
  - bus_addr and bus_wdat hold their values between accesses.
  - rd_stb and wr_stb are never high in the same cycle.
  - Only one pulse is emitted per access.
  - glitch_cnt saturates at 255 and does not wrap.
- Reset:
  - rst overrides everything, including mid-access.
  - Reset values: FSM = IDLE, rd_stb = 0, wr_stb = 0, bus_act = 0, bus_addr = 0, bus_wdat = 0, glitch_cnt = 0, fcnt = 0.
  - An access in progress at reset release produces no pulse. The FSM re-arms only after both strobes are seen high in IDLE.

Decomposition:
- Package cpu_bus_pkg holds:
  - typedef enum bus_state_t {IDLE, QUAL, ACTIVE, RELEASE};
  - typedef enum acc_kind_t {RD, WR};
  - function bitrev8.
- One sub-module, sync_ff: a parameterised-width, SYNC_STAGES-deep synchroniser with a reset value parameter, instantiated per pin group.

Test Plan:
- Clean read: cpu_addr = 0x01234, cpu_oe low for 20 clocks → one rd_stb exactly 6 clocks after the fall; bus_addr = 0x01234; bus_act high until 3 clocks after the synchronised oe rise (plus sync delay).
- Write, region=0: cpu_data = 0x5A, cpu_we low for 15 clocks → one wr_stb after release; bus_wdat = 0x5A.
- Write, region=1: cpu_data = 0x01 → bus_wdat = 0x80. Repeat with cpu_data = 0xC3 → bus_wdat = 0xC3.
- Glitches:
  - cpu_oe low for 2 clocks (FILT_CYC=3) → no rd_stb; glitch_cnt = 1.
  - oe and we low simultaneously → glitch_cnt = 2; no pulse.
- Release bounce: during a write, cpu_we goes high 1 clock, low 4 clocks, then high → exactly one wr_stb; data = the value present in the last low window; glitch_cnt unchanged.
- Reset mid-access: rst for 1 clock while cpu_oe is low in ACTIVE → all outputs zero; no rd_stb until oe goes high then low again. Then drive 300 glitches → glitch_cnt = 255.
